stream_mux4: RTL and testbench
==============================

# stream_mux4

Four-channel, packet-aware, round-robin stream multiplexer that merges four independent valid/ready input streams onto one output stream. It is the merge-side counterpart of the 1-to-4 demux: the demux fans one source out to four sinks, and this block collects four sources back onto one link. Each grant is held for a whole packet, marked by `in_last`, so packets never interleave. The output stage is registered, and a select tag records which channel each beat came from.

## Interface
- `WIDTH`, default 8: data width per beat.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable. Low blocks new grants and new input beats; the output register still drains.
- `in_data`  in  4*WIDTH  channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  4  per-channel beat valid.
- `in_last`  in  4  per-channel end-of-packet, qualified by `in_valid`.
- `in_ready`  out  4  per-channel accept.
- `dout`  out  WIDTH  registered output data.
- `dout_valid`  out  1  registered output valid.
- `dout_last`  out  1  registered end-of-packet.
- `dout_sel`  out  2  source channel of the current output beat.
- `dout_ready`  in  1  downstream accept.

## Operation
- Reset values (first edge with `rst`=1):
  - state IDLE; `gnt`=0; `last_gnt`=3, so channel 0 has top priority after reset.
  - `dout`=0, `dout_valid`=0, `dout_last`=0, `dout_sel`=0.
  - `in_ready`=0 in the same cycle that `rst` is high.
- State machine, two states:
  - IDLE: if `en` and `|in_valid`, register `gnt` = first requester searching `last_gnt+1, +2, +3, +4` (mod 4), then go to BUSY. No beat is accepted in IDLE.
  - BUSY: `in_ready[gnt]` = `en & (!dout_valid | dout_ready)`; all other `in_ready` bits are 0.
  - BUSY, on accept of a beat with `in_last[gnt]`=1: set `last_gnt`←`gnt` and return to IDLE.
- Output register:
  - On accept: `dout`←beat, `dout_last`←`in_last[gnt]`, `dout_sel`←`gnt`, `dout_valid`←1.
  - Else, if `dout_ready`: `dout_valid`←0.
  - `dout` and `dout_sel` are held while `dout_valid & !dout_ready`.
- `en` deasserted mid-packet: grant and state are held; input stalls; the packet resumes when `en` returns.
- `in_valid` dropped mid-packet by the granted source: the grant is held, because a packet ends only on a last beat.
- Non-granted channels may hold `in_valid` high indefinitely. None is starved: round-robin guarantees service within 3 packets.
- Single-beat packets (`in_valid` and `in_last` both high on the first beat) are legal.
- Synchronous reset mid-packet: the packet is abandoned, the output beat is dropped, and all outputs take their reset values.

## Timing
- Arbitration latency: 1 cycle (IDLE→BUSY). The first beat of a packet is accepted at the earliest in the 2nd cycle after `in_valid` rises.
- Data latency: output is valid in the cycle after input accept.
- Throughput:
  - 1 beat/cycle within a packet while `dout_ready`=1.
  - 1 idle cycle between packets (the IDLE arbitration cycle).
- Backpressure: `dout_ready`=0 with `dout_valid`=1 drops `in_ready` combinationally in the same cycle.
- Simultaneous events:
  - Accept with `dout_ready`=1 on the same edge: the register is overwritten and `dout_valid` stays 1.
  - Last beat with other channels requesting: IDLE is always visited for 1 cycle before the next grant.

## Structure
- Shared package/header holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1;
  - `NCH`=4;
  - channel-index width 2.
- Sub-module `rr_arbiter4` (combinational): inputs `req[3:0]` and `last_gnt[1:0]`; outputs `gnt_idx[1:0]` and `any`. Top level holds the FSM, the grant register and the output register.

## Test plan
- Reset then single request: `rst` 2 cycles; ch2 sends 1-beat packet 0xA5 with last → `in_ready[2]` high in cycle 2; next cycle `dout`=0xA5, `dout_sel`=2, `dout_last`=1, `dout_valid`=1.
- All four request 2-beat packets (ch i data 0x10*i, 0x10*i+1) with `dout_ready`=1 → output order ch0,1,2,3; beats never interleave; 1 idle cycle between packets.
- Fairness: ch0 requests continuously, ch3 raises a request during ch0's packet → ch3 is granted next, ahead of ch0's next packet.
- Backpressure: `dout_ready`=0 for 3 cycles mid-packet on ch1 → `dout` holds, `in_ready[1]`=0; resume → no beat lost or duplicated, 4-beat packet intact.
- `en` low 5 cycles mid-packet on ch0 → grant held, no accepts, output drains; `en` high → remaining beats come from ch0 only.
- `rst` asserted mid-packet → next cycle `dout_valid`=0, state IDLE, channel 0 has priority on the next arbitration.

Source files
------------

// File: rtl/stream_mux4_pkg.sv
// Shared definitions for the four-channel packet-aware stream multiplexer.
// Holds the channel count, the channel-index type and the FSM state encoding.
package stream_mux4_pkg;

  localparam int unsigned NCH    = 4;
  localparam int unsigned ChIdxW = 2;

  typedef logic [ChIdxW-1:0] ch_idx_t;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

endpackage

// File: rtl/stream_mux4_rr_arbiter4.sv
// Combinational four-way round-robin arbiter.
//   req      : per-channel request
//   last_gnt : channel granted most recently; search starts one past it
//   gnt_idx  : first requester found in order last_gnt+1 .. last_gnt+4 (mod 4)
//   any      : at least one request is present
module rr_arbiter4
  import stream_mux4_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  ch_idx_t        last_gnt,
  output ch_idx_t        gnt_idx,
  output logic           any
);

  ch_idx_t idx;

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    any     = |req;
    for (int k = NCH; k >= 1; k--) begin
      idx = last_gnt + ChIdxW'(k);
      if (req[idx]) begin
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux4.sv
// Four-to-one packet-aware round-robin stream multiplexer with a registered output.
// A grant is held from the first beat of a packet until its last beat is accepted.
//   clk, rst        : clock, synchronous active-high reset
//   en              : block enable; low stalls grants and input beats, output still drains
//   in_data         : channel i data at [i*WIDTH +: WIDTH]
//   in_valid/last   : per-channel beat valid and end-of-packet
//   in_ready        : per-channel accept
//   dout, dout_valid, dout_last, dout_sel : registered output beat and its source channel
//   dout_ready      : downstream accept
module stream_mux4
  import stream_mux4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  output logic [ChIdxW-1:0]    dout_sel,
  input  logic                 dout_ready
);

  state_e           state_q, state_d;
  ch_idx_t          gnt_q, gnt_d;
  ch_idx_t          last_gnt_q, last_gnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  ch_idx_t          dout_sel_q, dout_sel_d;

  ch_idx_t          arb_idx;
  logic             arb_any;
  logic             accept;
  logic             beat_last;
  logic [WIDTH-1:0] beat_data;

  rr_arbiter4 u_arb (
    .req      (in_valid),
    .last_gnt (last_gnt_q),
    .gnt_idx  (arb_idx),
    .any      (arb_any)
  );

  // Only the granted channel can be ready, and only when the output slot is free
  // or being emptied this cycle.
  always_comb begin
    in_ready = '0;
    if (!rst && state_q == StBusy) begin
      in_ready[gnt_q] = en && (!dout_valid_q || dout_ready);
    end
  end

  assign accept    = in_ready[gnt_q] & in_valid[gnt_q];
  assign beat_last = in_last[gnt_q];
  assign beat_data = in_data[gnt_q*WIDTH +: WIDTH];

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_gnt_d   = last_gnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_sel_d   = dout_sel_q;

    unique case (state_q)
      StIdle: begin
        if (en && arb_any) begin
          gnt_d   = arb_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (accept && beat_last) begin
          last_gnt_d = gnt_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      dout_d       = beat_data;
      dout_last_d  = beat_last;
      dout_sel_d   = gnt_q;
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      last_gnt_q   <= ch_idx_t'(NCH - 1);
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_sel_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_gnt_q   <= last_gnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_sel_q   <= dout_sel_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_sel   = dout_sel_q;

endmodule

// File: tb/tb_stream_mux4.sv
// Bench for stream_mux4: a per-cycle vector table for reset, single-beat packets,
// backpressure and enable, then queue-driven sources for the multi-packet cases.
module tb_stream_mux4;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic          en;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_valid;
  logic [3:0]    in_last;
  logic [3:0]    in_ready;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_last;
  logic [1:0]    dout_sel;
  logic          dout_ready;

  int n_chk  = 0;
  int n_fail = 0;

  stream_mux4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_sel   (dout_sel),
    .dout_ready (dout_ready)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One record per cycle: inputs applied, in_ready expected this cycle, and
  // registered outputs expected as seen before the closing edge.
  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        dready;
    logic [3:0]  exp_rdy;
    logic        chk_o;
    logic [7:0]  exp_dout;
    logic        exp_dv;
    logic        exp_dl;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[17];

  typedef struct {
    logic [1:0] sel;
    logic       last;
    logic [7:0] data;
    int         cyc;
  } beat_t;

  logic [8:0] src_q[4][$];
  beat_t      out_q[$];
  beat_t      exp_q[$];
  int         cyc;
  logic       hold_pend;
  logic [7:0] held_d;
  logic [1:0] held_s;

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i]        = 1'b1;
        in_data[i*W +: W]  = src_q[i][0][7:0];
        in_last[i]         = src_q[i][0][8];
      end else begin
        in_valid[i]        = 1'b0;
        in_data[i*W +: W]  = '0;
        in_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int ch, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      src_q[ch].push_back({(b == n - 1), 8'(base + 8'(b))});
      exp_q.push_back('{sel: 2'(ch), last: (b == n - 1), data: 8'(base + 8'(b)), cyc: 0});
    end
  endtask

  task automatic run_auto(input int n);
    logic [3:0] fire;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      fire = in_valid & in_ready;
      if (dout_valid && dout_ready) begin
        out_q.push_back('{sel: dout_sel, last: dout_last, data: dout, cyc: cyc});
      end
      if (hold_pend) begin
        check("hold_dout", {24'h0, dout}, {24'h0, held_d});
        check("hold_sel", {30'h0, dout_sel}, {30'h0, held_s});
      end
      hold_pend = dout_valid && !dout_ready;
      held_d    = dout;
      held_s    = dout_sel;
      if (dout_valid && !dout_ready) check("stall_rdy", {28'h0, in_ready}, 32'h0);
      if (!en) check("en_low_rdy", {28'h0, in_ready}, 32'h0);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) void'(src_q[i].pop_front());
      end
      drive_src();
    end
  endtask

  task automatic compare_beats(input string name, input logic chk_gap);
    check({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      check({name, "_beat"}, {21'h0, out_q[i].sel, out_q[i].last, out_q[i].data},
            {21'h0, exp_q[i].sel, exp_q[i].last, exp_q[i].data});
      if (chk_gap && i > 0) begin
        check({name, "_gap"}, 32'(out_q[i].cyc - out_q[i-1].cyc), exp_q[i-1].last ? 32'd2 : 32'd1);
      end
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    drive_src();
    @(negedge clk);
    check("rst_rdy", {28'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_dv", {31'h0, dout_valid}, 32'h0);
    hold_pend = 1'b0;
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    //          rst  en  valid    last     data          drdy rdy      chk dout  dv  dl  sel
    vecs[0]  = '{1, 1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'h00, 0, 0, 2'd0};
    vecs[1]  = '{1, 1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 1, 8'h00, 0, 0, 2'd0};
    vecs[2]  = '{0, 1, 4'b0100, 4'b0100, 32'h00A50000, 1, 4'b0000, 1, 8'h00, 0, 0, 2'd0};
    vecs[3]  = '{0, 1, 4'b0100, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'h00, 0, 0, 2'd0};
    vecs[4]  = '{0, 1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 1, 8'hA5, 1, 1, 2'd2};
    vecs[5]  = '{0, 1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 1, 8'hA5, 0, 1, 2'd2};
    vecs[6]  = '{0, 1, 4'b0010, 4'b0010, 32'h00003C00, 0, 4'b0000, 1, 8'hA5, 0, 1, 2'd2};
    vecs[7]  = '{0, 1, 4'b0010, 4'b0010, 32'h00003C00, 0, 4'b0010, 1, 8'hA5, 0, 1, 2'd2};
    vecs[8]  = '{0, 1, 4'b0010, 4'b0010, 32'h00003D00, 0, 4'b0000, 1, 8'h3C, 1, 1, 2'd1};
    vecs[9]  = '{0, 1, 4'b0010, 4'b0010, 32'h00003D00, 0, 4'b0000, 1, 8'h3C, 1, 1, 2'd1};
    vecs[10] = '{0, 1, 4'b0010, 4'b0010, 32'h00003D00, 1, 4'b0010, 1, 8'h3C, 1, 1, 2'd1};
    vecs[11] = '{0, 1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 1, 8'h3D, 1, 1, 2'd1};
    vecs[12] = '{0, 0, 4'b0001, 4'b0001, 32'h00000077, 1, 4'b0000, 1, 8'h3D, 0, 1, 2'd1};
    vecs[13] = '{0, 0, 4'b0001, 4'b0001, 32'h00000077, 1, 4'b0000, 1, 8'h3D, 0, 1, 2'd1};
    vecs[14] = '{0, 1, 4'b0001, 4'b0001, 32'h00000077, 1, 4'b0000, 1, 8'h3D, 0, 1, 2'd1};
    vecs[15] = '{0, 1, 4'b0001, 4'b0001, 32'h00000077, 1, 4'b0001, 1, 8'h3D, 0, 1, 2'd1};
    vecs[16] = '{0, 1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 1, 8'h77, 1, 1, 2'd0};

    cyc       = 0;
    hold_pend = 1'b0;
    held_d    = '0;
    held_s    = '0;

    for (int v = 0; v < 17; v++) begin
      rst        = vecs[v].rst;
      en         = vecs[v].en;
      in_valid   = vecs[v].valid;
      in_last    = vecs[v].last;
      in_data    = vecs[v].data;
      dout_ready = vecs[v].dready;
      @(negedge clk);
      check($sformatf("v%0d_rdy", v), {28'h0, in_ready}, {28'h0, vecs[v].exp_rdy});
      if (vecs[v].chk_o) begin
        check($sformatf("v%0d_out", v),
              {20'h0, dout_sel, dout_last, dout_valid, dout},
              {20'h0, vecs[v].exp_sel, vecs[v].exp_dl, vecs[v].exp_dv, vecs[v].exp_dout});
      end
      @(posedge clk);
      #1;
    end

    // All four channels with 2-beat packets: served 0,1,2,3 with one idle cycle between.
    en = 1'b1;
    dout_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) push_pkt(i, 8'(8'h10 * i), 2);
    drive_src();
    run_auto(18);
    compare_beats("rr4", 1'b1);

    // Fairness: ch3 raised during ch0's packet is served before ch0's next packet.
    push_pkt(0, 8'h40, 3);
    drive_src();
    run_auto(3);
    src_q[3].push_back({1'b1, 8'h90});
    exp_q.push_back('{sel: 2'd3, last: 1'b1, data: 8'h90, cyc: 0});
    for (int b = 0; b < 3; b++) begin
      src_q[0].push_back({(b == 2), 8'(8'h43 + 8'(b))});
      exp_q.push_back('{sel: 2'd0, last: (b == 2), data: 8'(8'h43 + 8'(b)), cyc: 0});
    end
    drive_src();
    run_auto(15);
    compare_beats("fair", 1'b0);

    // Backpressure for 3 cycles mid-packet on ch1.
    push_pkt(1, 8'h50, 4);
    drive_src();
    run_auto(3);
    dout_ready = 1'b0;
    run_auto(3);
    dout_ready = 1'b1;
    run_auto(6);
    compare_beats("bp", 1'b0);

    // Enable low 5 cycles mid-packet on ch0 while ch1 also requests.
    push_pkt(0, 8'h60, 4);
    push_pkt(1, 8'h70, 2);
    drive_src();
    run_auto(3);
    en = 1'b0;
    run_auto(5);
    check("en_drain_dv", {31'h0, dout_valid}, 32'h0);
    en = 1'b1;
    run_auto(12);
    compare_beats("en", 1'b0);

    // Reset mid-packet on ch2: packet abandoned, ch0 regains top priority.
    push_pkt(2, 8'hB0, 3);
    drive_src();
    run_auto(3);
    check("pre_rst_dv", {31'h0, dout_valid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy", {28'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_out", {20'h0, dout_sel, dout_last, dout_valid, dout}, 32'h0);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    out_q.delete();
    exp_q.delete();
    hold_pend = 1'b0;
    src_q[3].push_back({1'b1, 8'hC3});
    src_q[0].push_back({1'b1, 8'hC0});
    exp_q.push_back('{sel: 2'd0, last: 1'b1, data: 8'hC0, cyc: 0});
    exp_q.push_back('{sel: 2'd3, last: 1'b1, data: 8'hC3, cyc: 0});
    drive_src();
    run_auto(8);
    compare_beats("rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
